scene_pixel_renderer: RTL

- Consumer end of the game-logic scene interface.
- Takes the tile map, the sprite positions, show_hearts and lives, and produces 640x480@60 VGA timing and 24-bit pixel colour.
- Scene inputs are shadow-latched once per frame at the start of vertical blank, so changes mid-frame never tear.
- Sits between the game-logic block and the board VGA DAC pins.

---
 rtl/scene_pkg.sv | 63 ++++++
 rtl/vga_timing_gen.sv | 52 +++++
 rtl/scene_pixel_renderer.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/scene_pkg.sv
// Shared types and constants for the scene renderer: tile codes, VGA timing, colours.
package scene_pkg;

  localparam int SCREEN_WIDTH    = 640;
  localparam int SCREEN_HEIGHT   = 480;
  localparam int BLOCK_WIDTH     = 40;
  localparam int CHARACTER_WIDTH = 42;
  localparam int H_FRONT = 16;
  localparam int H_SYNC  = 96;
  localparam int H_BACK  = 48;
  localparam int V_FRONT = 10;
  localparam int V_SYNC  = 2;
  localparam int V_BACK  = 33;

  localparam int TILE_ROWS = 12;
  localparam int TILE_COLS = 17;

  typedef logic [7:0]  tile_code_t;
  typedef logic [10:0] cnt_t;
  typedef logic [23:0] rgb_t;
  typedef tile_code_t [TILE_ROWS-1:0][TILE_COLS-1:0] tile_map_t;

  localparam tile_code_t BDR = 8'd0;
  localparam tile_code_t SKY = 8'd1;
  localparam tile_code_t BLK = 8'd2;
  localparam tile_code_t GND = 8'd3;
  localparam tile_code_t TKN = 8'd4;
  localparam tile_code_t CK1 = 8'd5;
  localparam tile_code_t CK2 = 8'd6;

  localparam rgb_t RGB_BDR    = 24'h000000;
  localparam rgb_t RGB_SKY    = 24'h5C94FC;
  localparam rgb_t RGB_BLK    = 24'hC84C0C;
  localparam rgb_t RGB_GND    = 24'h8B4513;
  localparam rgb_t RGB_TKN    = 24'hFCD800;
  localparam rgb_t RGB_CK1    = 24'h00A800;
  localparam rgb_t RGB_CK2    = 24'hFCFCFC;
  localparam rgb_t RGB_BAD    = 24'hFF00FF;
  localparam rgb_t RGB_HEART  = 24'hFF0000;
  localparam rgb_t RGB_MARIO  = 24'hE0301C;
  localparam rgb_t RGB_GOOMBA = 24'h9C4A00;

  // Lives HUD geometry: up to three 16x16 hearts along the top-left corner.
  localparam int HEART_X0    = 8;
  localparam int HEART_PITCH = 24;
  localparam int HEART_SIZE  = 16;
  localparam int HEART_Y0    = 8;
  localparam int HEART_COUNT = 3;

  function automatic rgb_t tile_colour(input tile_code_t code);
    case (code)
      BDR:     return RGB_BDR;
      SKY:     return RGB_SKY;
      BLK:     return RGB_BLK;
      GND:     return RGB_GND;
      TKN:     return RGB_TKN;
      CK1:     return RGB_CK1;
      CK2:     return RGB_CK2;
      default: return RGB_BAD;
    endcase
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// VGA raster counters with raw (undelayed) sync, visible flag and the frame latch strobe.
// Outputs are combinational from the counters; no backpressure, free-running.
module vga_timing_gen
  import scene_pkg::*;
#(
  parameter int SCREEN_W = SCREEN_WIDTH,
  parameter int SCREEN_H = SCREEN_HEIGHT,
  parameter int HFP      = H_FRONT,
  parameter int HSW      = H_SYNC,
  parameter int HBP      = H_BACK,
  parameter int VFP      = V_FRONT,
  parameter int VSW      = V_SYNC,
  parameter int VBP      = V_BACK
) (
  input  logic clk,
  input  logic rst_n,
  output cnt_t hcount,
  output cnt_t vcount,
  output logic hs,
  output logic vs,
  output logic vis,
  output logic frame_tick
);

  localparam cnt_t H_VIS    = cnt_t'(SCREEN_W);
  localparam cnt_t V_VIS    = cnt_t'(SCREEN_H);
  localparam cnt_t H_LAST   = cnt_t'(SCREEN_W + HFP + HSW + HBP - 1);
  localparam cnt_t V_LAST   = cnt_t'(SCREEN_H + VFP + VSW + VBP - 1);
  localparam cnt_t HS_START = cnt_t'(SCREEN_W + HFP);
  localparam cnt_t HS_END   = cnt_t'(SCREEN_W + HFP + HSW);
  localparam cnt_t VS_START = cnt_t'(SCREEN_H + VFP);
  localparam cnt_t VS_END   = cnt_t'(SCREEN_H + VFP + VSW);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcount <= '0;
      vcount <= '0;
    end else if (hcount == H_LAST) begin
      hcount <= '0;
      vcount <= (vcount == V_LAST) ? '0 : vcount + cnt_t'(1);
    end else begin
      hcount <= hcount + cnt_t'(1);
    end
  end

  assign hs  = !(hcount >= HS_START && hcount < HS_END);
  assign vs  = !(vcount >= VS_START && vcount < VS_END);
  assign vis = (hcount < H_VIS) && (vcount < V_VIS);
  // First cycle of vertical blank: the only point where the scene may be re-sampled.
  assign frame_tick = (hcount == '0) && (vcount == V_VIS);

endmodule

// File: rtl/scene_pixel_renderer.sv
// Renders tile map, three sprites and a lives HUD to 24-bit VGA; scene shadowed once per frame.
// Two-cycle pixel latency with sync/blank delayed to match; free-running, no backpressure.
module scene_pixel_renderer
  import scene_pkg::*;
#(
  parameter int SCREEN_W = SCREEN_WIDTH,
  parameter int SCREEN_H = SCREEN_HEIGHT,
  parameter int BLOCK_W  = BLOCK_WIDTH,
  parameter int CHAR_W   = CHARACTER_WIDTH,
  parameter int HFP      = H_FRONT,
  parameter int HSW      = H_SYNC,
  parameter int HBP      = H_BACK,
  parameter int VFP      = V_FRONT,
  parameter int VSW      = V_SYNC,
  parameter int VBP      = V_BACK
) (
  input  logic       vga_clock,
  input  logic       reset,
  input  tile_map_t  background,
  input  int         mario_x,
  input  int         mario_y,
  input  int         goomba_x,
  input  int         goomba_y,
  input  int         goomba_2x,
  input  int         goomba_2y,
  input  logic       show_hearts,
  input  int         lives,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_blank_n,
  output logic [7:0] vga_r,
  output logic [7:0] vga_g,
  output logic [7:0] vga_b,
  output logic       frame_start
);

  localparam int OFFSCREEN = 1000;

  cnt_t hcount, vcount;
  logic raw_hs, raw_vs, raw_vis, frame_tick;

  vga_timing_gen #(
    .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H),
    .HFP(HFP), .HSW(HSW), .HBP(HBP),
    .VFP(VFP), .VSW(VSW), .VBP(VBP)
  ) u_timing (
    .clk        (vga_clock),
    .rst_n      (reset),
    .hcount     (hcount),
    .vcount     (vcount),
    .hs         (raw_hs),
    .vs         (raw_vs),
    .vis        (raw_vis),
    .frame_tick (frame_tick)
  );

  tile_map_t sh_bg;
  int        sh_mx, sh_my, sh_gx, sh_gy, sh_g2x, sh_g2y, sh_lives;
  logic      sh_show;

  always_ff @(posedge vga_clock or negedge reset) begin
    if (!reset) begin
      sh_bg    <= {(TILE_ROWS * TILE_COLS){SKY}};
      sh_mx    <= OFFSCREEN;
      sh_my    <= OFFSCREEN;
      sh_gx    <= OFFSCREEN;
      sh_gy    <= OFFSCREEN;
      sh_g2x   <= OFFSCREEN;
      sh_g2y   <= OFFSCREEN;
      sh_lives <= 0;
      sh_show  <= 1'b0;
    end else if (frame_tick) begin
      sh_bg    <= background;
      sh_mx    <= mario_x;
      sh_my    <= mario_y;
      sh_gx    <= goomba_x;
      sh_gy    <= goomba_y;
      sh_g2x   <= goomba_2x;
      sh_g2y   <= goomba_2y;
      sh_lives <= lives;
      sh_show  <= show_hearts;
    end
  end

  function automatic logic sprite_span(input int start, input int pos);
    return (start <= pos) && (pos < start + CHAR_W);
  endfunction

  int         hx, vy, col_full, row_full;
  logic [4:0] col_idx;
  logic [3:0] row_idx;
  tile_code_t tile;
  logic       mario_hit, goomba_hit, heart_hit;

  always_comb begin
    hx       = int'(hcount);
    vy       = int'(vcount);
    col_full = hx / BLOCK_W;
    row_full = vy / BLOCK_W;
    col_idx  = col_full[4:0];
    row_idx  = row_full[3:0];
    tile     = BDR;
    if (col_full < TILE_COLS && row_full < TILE_ROWS)
      tile = sh_bg[row_idx][col_idx];

    mario_hit  = sprite_span(sh_mx, hx) && sprite_span(sh_my, vy);
    goomba_hit = (sprite_span(sh_gx, hx) && sprite_span(sh_gy, vy)) ||
                 (sprite_span(sh_g2x, hx) && sprite_span(sh_g2y, vy));

    // Signed compare against lives: zero or negative shows nothing, above three caps at three.
    heart_hit = 1'b0;
    for (int i = 0; i < HEART_COUNT; i++) begin
      if (sh_show && i < sh_lives &&
          hx >= HEART_X0 + HEART_PITCH * i &&
          hx <  HEART_X0 + HEART_PITCH * i + HEART_SIZE &&
          vy >= HEART_Y0 && vy < HEART_Y0 + HEART_SIZE)
        heart_hit = 1'b1;
    end
  end

  tile_code_t s1_tile;
  logic       s1_heart, s1_mario, s1_goomba, s1_vis, s1_hs, s1_vs;

  always_ff @(posedge vga_clock or negedge reset) begin
    if (!reset) begin
      s1_tile   <= BDR;
      s1_heart  <= 1'b0;
      s1_mario  <= 1'b0;
      s1_goomba <= 1'b0;
      s1_vis    <= 1'b0;
      s1_hs     <= 1'b1;
      s1_vs     <= 1'b1;
    end else begin
      s1_tile   <= tile;
      s1_heart  <= heart_hit;
      s1_mario  <= mario_hit;
      s1_goomba <= goomba_hit;
      s1_vis    <= raw_vis;
      s1_hs     <= raw_hs;
      s1_vs     <= raw_vs;
    end
  end

  rgb_t pix;

  always_comb begin
    pix = '0;
    if (s1_vis) begin
      if (s1_heart)       pix = RGB_HEART;
      else if (s1_mario)  pix = RGB_MARIO;
      else if (s1_goomba) pix = RGB_GOOMBA;
      else                pix = tile_colour(s1_tile);
    end
  end

  always_ff @(posedge vga_clock or negedge reset) begin
    if (!reset) begin
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_blank_n <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      vga_r       <= pix[23:16];
      vga_g       <= pix[15:8];
      vga_b       <= pix[7:0];
      vga_hs      <= s1_hs;
      vga_vs      <= s1_vs;
      vga_blank_n <= s1_vis;
      frame_start <= frame_tick;
    end
  end

endmodule
